uart_wave_loader: RTL

UART receive-side loader for wave sample memory: the host-to-FPGA counterpart of the UART sample debugger. Deserializes 8N1 bytes on `uart_rx` at 25 MHz and parses a framed packet (sync, 16-bit length, 16-bit samples). Emits one sample-memory write per received sample, then publishes the new wave width. Sits between the board UART RX pin and the wave sample RAM write port.

---
 rtl/uart_wave_loader.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_wave_loader.sv
`timescale 1ns/1ps
// UART 8N1 receiver plus packet parser that streams 16-bit wave samples into
// the sample RAM write port and publishes the completed wave width.
module uart_wave_loader #(
  parameter int         CLKS_PER_BIT = 217,
  parameter int         TIMEOUT_CLKS = 25000,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        clk_25mhz,
  input  logic        rst_in,
  input  logic        uart_rx,
  output logic [15:0] sample_index_out,
  output logic [15:0] sample_data_out,
  output logic        sample_we_out,
  output logic [15:0] wave_width_out,
  output logic        load_done_out,
  output logic        frame_err_out,
  output logic        busy_out
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam int            TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {P_WAIT_SYNC, P_LEN_LO, P_LEN_HI, P_DATA_LO, P_DATA_HI} pkt_state_t;

  logic          rx_meta_q, rx_s_q;
  rx_state_t     rstate_q, rstate_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          stop_wait_q, stop_wait_d;
  logic          byte_valid_q, byte_valid_d;
  logic          byte_err_q, byte_err_d;

  // Bit receiver: synchronizer and state register
  always_ff @(posedge clk_25mhz) begin
    if (rst_in) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rstate_q     <= R_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      stop_wait_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
    end else begin
      rx_meta_q    <= uart_rx;
      rx_s_q       <= rx_meta_q;
      rstate_q     <= rstate_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      stop_wait_q  <= stop_wait_d;
      byte_valid_q <= byte_valid_d;
      byte_err_q   <= byte_err_d;
    end
    shift_q <= shift_d;
  end

  always_comb begin
    rstate_d     = rstate_q;
    cnt_d        = cnt_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    stop_wait_d  = stop_wait_q;
    byte_valid_d = 1'b0;
    byte_err_d   = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        cnt_d       = '0;
        stop_wait_d = 1'b0;
        if (!rx_s_q) rstate_d = R_START;
      end
      R_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          rstate_d  = rx_s_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) rstate_d = R_STOP;
        end
      end
      R_STOP: begin
        // After a bad stop bit, hold here until the line returns idle
        if (stop_wait_q) begin
          cnt_d = '0;
          if (rx_s_q) begin
            stop_wait_d = 1'b0;
            rstate_d    = R_IDLE;
          end
        end else if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_valid_d = 1'b1;
            rstate_d     = R_IDLE;
          end else begin
            byte_err_d  = 1'b1;
            stop_wait_d = 1'b1;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  pkt_state_t    pstate_q, pstate_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   idx_q, idx_d;
  logic [15:0]   idx_inc;
  logic [7:0]    lo_q, lo_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   sidx_q, sidx_d;
  logic [15:0]   sdata_q, sdata_d;
  logic [15:0]   width_q, width_d;
  logic          we_q, we_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          busy;

  // Packet FSM: state and output registers
  always_ff @(posedge clk_25mhz) begin
    if (rst_in) begin
      pstate_q <= P_WAIT_SYNC;
      tmo_q    <= '0;
      sidx_q   <= '0;
      sdata_q  <= '0;
      width_q  <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      tmo_q    <= tmo_d;
      sidx_q   <= sidx_d;
      sdata_q  <= sdata_d;
      width_q  <= width_d;
      we_q     <= we_d;
      done_q   <= done_d;
      ferr_q   <= ferr_d;
    end
    len_q <= len_d;
    idx_q <= idx_d;
    lo_q  <= lo_d;
  end

  assign busy    = (pstate_q != P_WAIT_SYNC);
  assign idx_inc = idx_q + 16'd1;

  always_comb begin
    pstate_d = pstate_q;
    len_d    = len_q;
    idx_d    = idx_q;
    lo_d     = lo_q;
    sidx_d   = sidx_q;
    sdata_d  = sdata_q;
    width_d  = width_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    ferr_d   = ferr_q;
    if (!busy || byte_valid_q) tmo_d = '0;
    else                       tmo_d = tmo_q + 1'b1;

    // Abort wins over a byte arriving in the same cycle
    if (busy && (byte_err_q || tmo_q == TMO_LAST)) begin
      pstate_d = P_WAIT_SYNC;
      ferr_d   = 1'b1;
    end else if (byte_valid_q) begin
      case (pstate_q)
        P_WAIT_SYNC: begin
          if (shift_q == SYNC_BYTE) begin
            pstate_d = P_LEN_LO;
            ferr_d   = 1'b0;
            idx_d    = '0;
          end
        end
        P_LEN_LO: begin
          len_d    = {len_q[15:8], shift_q};
          pstate_d = P_LEN_HI;
        end
        P_LEN_HI: begin
          len_d = {shift_q, len_q[7:0]};
          if ({shift_q, len_q[7:0]} == 16'd0) begin
            ferr_d   = 1'b1;
            pstate_d = P_WAIT_SYNC;
          end else begin
            pstate_d = P_DATA_LO;
          end
        end
        P_DATA_LO: begin
          lo_d     = shift_q;
          pstate_d = P_DATA_HI;
        end
        P_DATA_HI: begin
          sdata_d = {shift_q, lo_q};
          sidx_d  = idx_q;
          we_d    = 1'b1;
          idx_d   = idx_inc;
          if (idx_inc == len_q) begin
            width_d  = len_q;
            done_d   = 1'b1;
            pstate_d = P_WAIT_SYNC;
          end else begin
            pstate_d = P_DATA_LO;
          end
        end
        default: pstate_d = P_WAIT_SYNC;
      endcase
    end
  end

  assign sample_index_out = sidx_q;
  assign sample_data_out  = sdata_q;
  assign sample_we_out    = we_q;
  assign wave_width_out   = width_q;
  assign load_done_out    = done_q;
  assign frame_err_out    = ferr_q;
  assign busy_out         = busy;

endmodule
